div_32: RTL and testbench
=========================

# div_32

Sequential 32-bit signed integer divider for the ALU datapath's multicycle (mult/div) path. It accepts a dividend/divisor pair on a start strobe and runs one restoring shift-subtract step per clock. After a fixed latency it returns quotient, remainder and an exception flag with a one-cycle ready pulse. The pipeline stalls on `busy` and captures results on `data_resultRDY`.

## Interface
- `WIDTH`, default 32: operand/result width in bits. Only 32 is verified.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ctrl_DIV`  in  1: start strobe, sampled every rising edge.
- `data_operandA`  in  32: dividend, two's complement. Sampled only on the accepting edge.
- `data_operandB`  in  32: divisor, two's complement. Sampled only on the accepting edge.
- `data_result`  out  32: quotient.
- `data_remainder`  out  32: remainder.
- `data_exception`  out  1: divide-by-zero or overflow for the last completed operation.
- `data_resultRDY`  out  1: one-cycle completion pulse.
- `busy`  out  1: high while an operation is in progress (state RUN).

## Operation
- States:
  - IDLE: waiting for a start strobe.
  - RUN: 32 iterations, tracked by a 5-bit counter, 0..31.
  - DONE: exactly one cycle.
- Accept: `ctrl_DIV`=1 at an edge in IDLE or DONE starts a new operation.
  - Latch |A|, |B|, sign(A), sign(A) XOR sign(B), and the zero/overflow flags.
  - Clear the partial remainder and set counter=0. Next state is RUN.
- `ctrl_DIV` while in RUN is ignored: no restart, no queueing, latched operands unchanged.
- Each RUN edge:
  - Form {rem, quo} shifted left 1. Trial = rem_shifted − |B|, computed at 33 bits.
  - If the trial is non-negative, rem = trial and the quotient LSB = 1. Otherwise the quotient LSB = 0.
  - Counter increments. At counter=31 the next state is DONE.
- Entering DONE registers the outputs:
  - Quotient is negated if the latched quotient sign is 1.
  - Remainder is negated if the latched dividend sign is 1.
  - Truncation is toward zero; the remainder takes the dividend's sign.
- Divisor = 0: `data_result`=0, `data_remainder`=dividend, `data_exception`=1. Latency is unchanged and the datapath iterations are don't-care.
- Dividend 0x80000000 with divisor 0xFFFFFFFF: `data_result`=0x80000000, `data_remainder`=0, `data_exception`=1.
- |−2^31| = 0x80000000 is treated as unsigned magnitude. No other operand pair raises an exception.
- `data_result`, `data_remainder` and `data_exception` hold their values from DONE until the next DONE or reset.
- `data_resultRDY` is 1 only in DONE.

## Timing
- Reset (edge with `reset`=1) takes priority over everything. Registered state after that edge:
  - state = IDLE, counter = 0
  - `busy` = 0, `data_resultRDY` = 0
  - `data_result` = 0, `data_remainder` = 0, `data_exception` = 0
- Reset mid-RUN aborts the operation. No `data_resultRDY` pulse is produced for it.
- Latency: start accepted at edge E0 (cycle 0). `busy`=1 for cycles 1..32. `data_resultRDY`=1 and outputs valid in cycle 33.
- Back-to-back: `ctrl_DIV`=1 during the DONE cycle is accepted at that edge. The next result appears 33 cycles later, so throughput is one divide per 33 cycles.
- `busy` and `data_resultRDY` are never high in the same cycle.
- Both are registered and have no combinational path from the inputs.
- Operand inputs may change freely after the accepting edge.

## Test plan
- Positive divide: A=100, B=7, `ctrl_DIV` pulsed in cycle 0. Expect `busy` high in cycles 1..32, then `data_resultRDY`=1 in cycle 33 with `data_result`=14, `data_remainder`=2, `data_exception`=0. `data_resultRDY`=0 in cycle 34 and the outputs hold.
- Sign handling, A and B swept over all four sign combinations:
  - 100/7 gives 14 r 2.
  - −100/7 gives −14 (0xFFFFFFF2) r −2 (0xFFFFFFFE).
  - 100/−7 gives −14 r 2.
  - −100/−7 gives 14 r −2.
- Exceptions:
  - A=5, B=0: cycle 33 shows `data_result`=0, `data_remainder`=5, `data_exception`=1.
  - A=0x80000000, B=0xFFFFFFFF: `data_result`=0x80000000, `data_exception`=1.
  - A=0x80000000, B=1: `data_result`=0x80000000, `data_exception`=0.
- Start-strobe handling:
  - `ctrl_DIV` pulsed in cycle 10 of an op with new operands: it is ignored, and the result for the original operands arrives at cycle 33.
  - `ctrl_DIV` asserted in the DONE cycle (33) with A=9, B=3: accepted, and `data_result`=3 arrives in cycle 66.
- Reset mid-operation: start in cycle 0, `reset` high in cycle 10.
  - Cycle 11: all outputs are 0 and `busy`=0.
  - No `data_resultRDY` pulse for the aborted op.
  - A fresh start after reset completes normally 33 cycles later.
- Randomized: 1000 random signed pairs, including 0, ±1, 0x7FFFFFFF and 0x80000000. Checked against a reference model for quotient, remainder and exception, and for fixed 33-cycle latency.

Source files
------------

// File: rtl/div_32.sv
// rtl/div_32.sv - sequential signed restoring divider, one quotient bit per clock
// Start is accepted in IDLE or DONE; quotient/remainder/exception register on entry to DONE.
module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d, a_q, a_d;
  logic             sa_q, sa_d, sq_q, sq_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] res_q, res_d, remo_q, remo_d;
  logic             exc_q, exc_d;

  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] step_rem, step_quo;

  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, div_q};
    // A borrow in the trial subtraction means the divisor did not fit this step.
    step_rem = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    a_d     = a_q;
    sa_d    = sa_q;
    sq_d    = sq_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    remo_d  = remo_q;
    exc_d   = exc_q;

    case (state_q)
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          exc_d   = dz_q | ovf_q;
          if (dz_q) begin
            res_d  = '0;
            remo_d = a_q;
          end else begin
            res_d  = sq_q ? -step_quo : step_quo;
            remo_d = sa_q ? -step_rem : step_rem;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (ctrl_DIV) begin
          state_d = RUN;
          cnt_d   = '0;
          rem_d   = '0;
          a_d     = data_operandA;
          quo_d   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
          div_d   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
          sa_d    = data_operandA[WIDTH-1];
          sq_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          dz_d    = (data_operandB == '0);
          ovf_d   = (data_operandA == MIN_NEG) && (data_operandB == '1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sq_q    <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      remo_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      a_q     <= a_d;
      sa_q    <= sa_d;
      sq_q    <= sq_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      remo_q  <= remo_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_remainder = remo_q;
  assign data_exception = exc_q;
  assign busy           = (state_q == RUN);
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_div_32.sv
// tb/tb_div_32.sv - directed and randomized scoreboard bench for div_32
module tb_div_32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result, data_remainder;
  logic        data_exception, data_resultRDY, busy;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  div_32 #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    logic signed [31:0] sa, sb_;
    sa  = a;
    sb_ = b;
    if (b == 32'd0) begin
      x.q = 32'd0; x.r = a; x.e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      x.q = 32'h8000_0000; x.r = 32'd0; x.e = 1'b1;
    end else begin
      x.q = sa / sb_; x.r = sa % sb_; x.e = 1'b0;
    end
    return x;
  endfunction

  // Drives one start strobe; operands are scrambled right after the accepting edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b, input bit push);
    if (push) sb.push_back(model(a, b));
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called in cycle 1 of an op; returns in the ready cycle (or after a timeout).
  task automatic wait_done(input string tag, input int glitch);
    int   lat = 1;
    int   busy_bad = 0;
    exp_t x;
    while (!data_resultRDY && lat < 40) begin
      if (!busy) busy_bad++;
      if (lat == glitch) begin
        ctrl_DIV = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
      end
      tick();
      ctrl_DIV = 1'b0;
      lat++;
    end
    check({tag, ".rdy"}, 32'(data_resultRDY), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'd33);
    check({tag, ".busy_run"}, 32'(busy_bad), 32'd0);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check({tag, ".q"}, data_result, x.q);
      check({tag, ".r"}, data_remainder, x.r);
      check({tag, ".e"}, 32'(data_exception), 32'(x.e));
    end
  endtask

  logic [31:0] corners [8] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'd7, 32'hFFFF_FF9C, 32'h8000_0001};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 200)) - 32'd100;
    return $urandom;
  endfunction

  initial begin
    int saw_rdy;
    tick();
    tick();
    check("rst.result", data_result, 32'd0);
    check("rst.remainder", data_remainder, 32'd0);
    check("rst.exception", 32'(data_exception), 32'd0);
    check("rst.rdy", 32'(data_resultRDY), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    start(32'd100, 32'd7, 1'b1);
    wait_done("pos", 0);
    tick();
    check("hold.rdy", 32'(data_resultRDY), 32'd0);
    check("hold.q", data_result, 32'd14);
    check("hold.r", data_remainder, 32'd2);
    check("hold.busy", 32'(busy), 32'd0);

    start(-32'd100, 32'd7, 1'b1);  wait_done("neg_pos", 0);
    start(32'd100, -32'd7, 1'b1);  wait_done("pos_neg", 0);
    start(-32'd100, -32'd7, 1'b1); wait_done("neg_neg", 0);
    start(32'd5, 32'd0, 1'b1);     wait_done("div0", 0);
    start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done("ovf", 0);
    start(32'h8000_0000, 32'd1, 1'b1);         wait_done("min_by1", 0);

    start(32'd100, 32'd7, 1'b1);
    wait_done("ignored_start", 10);
    start(32'd9, 32'd3, 1'b1);
    wait_done("back_to_back", 0);
    tick();

    start(32'd100, 32'd7, 1'b0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.result", data_result, 32'd0);
    check("abort.remainder", data_remainder, 32'd0);
    check("abort.exception", 32'(data_exception), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.rdy", 32'(data_resultRDY), 32'd0);
    saw_rdy = 0;
    repeat (40) begin
      tick();
      if (data_resultRDY) saw_rdy++;
    end
    check("abort.no_pulse", 32'(saw_rdy), 32'd0);
    start(32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_done("after_reset", 0);

    for (int i = 0; i < 1000; i++) begin
      start(pick(), pick(), 1'b1);
      wait_done("rand", 0);
    end

    check("sb.drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
